// File: rtl/instr_prefetch.sv
// Instruction prefetcher: reads a byte-wide memory one byte per cycle,
// decodes the instruction length from the icode in byte 0, and presents a
// zero-filled 10-byte instruction word with an out-of-range flag.
//
// Handshake: a request is taken when req=1 in a cycle where busy=0
// (IDLE or DONE). Memory reads are fire-and-forget: mem_rd_en/mem_addr in
// cycle N return mem_rdata in cycle N+1. instr_valid is a one-cycle pulse.
module instr_prefetch #(
    parameter int MEM_SIZE = 1024,
    parameter int MAX_LEN  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [63:0] pc_in,
    output logic        busy,
    output logic        mem_rd_en,
    output logic [63:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [0:79] instr,
    output logic        instr_valid,
    output logic [3:0]  instr_len,
    output logic        mem_error,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;

    logic [63:0] r_base;      // PC of the instruction being fetched
    logic [3:0]  r_cnt;       // FETCH cycle index; also the byte index issued this cycle
    logic [3:0]  r_len;       // decoded length, valid once byte 0 is captured
    logic        r_prev_oor;  // byte slot of the previous cycle was out of range
    logic [0:79] r_buf;       // assembly buffer, zero at start of each fetch
    logic        r_err;       // an out-of-range needed byte has been seen
    logic [0:79] r_instr;
    logic [3:0]  r_instr_len;
    logic        r_mem_error;

    logic [64:0] w_addr65;
    logic        w_oor;
    logic        w_slot;
    logic        w_rd_en;
    logic        w_cap;
    logic [3:0]  w_cap_idx;
    logic [6:0]  w_bit_base;
    logic [7:0]  w_byte;
    logic [3:0]  w_len_now;
    logic        w_last;
    logic        w_err_nx;
    logic        w_accept;
    logic [0:79] w_buf;

    function automatic logic [3:0] decode_len(input logic [3:0] icode);
        case (icode)
            4'h0, 4'h1, 4'h9:       decode_len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: decode_len = 4'd2;
            4'h3, 4'h4, 4'h5:       decode_len = 4'd10;
            4'h7, 4'h8:             decode_len = 4'd9;
            default:                decode_len = 4'd1;
        endcase
    endfunction

    // Datapath decode: address/range of the byte issued this cycle and the
    // byte captured from the read issued last cycle.
    always_comb begin
        w_addr65   = {1'b0, r_base} + {61'd0, r_cnt};
        w_oor      = (w_addr65 >= 65'(MEM_SIZE));
        // Bytes 0 and 1 go out before the length is known; later ones only if needed.
        w_slot     = (r_state == S_FETCH) && (r_cnt < 4'(MAX_LEN)) &&
                     ((r_cnt < 4'd2) || (r_cnt < r_len));
        w_rd_en    = w_slot && !w_oor;
        w_cap      = (r_state == S_FETCH) && (r_cnt != 4'd0);
        w_cap_idx  = r_cnt - 4'd1;
        w_bit_base = {w_cap_idx, 3'b000};
        // Out-of-range bytes were never read and count as 0x00.
        w_byte     = r_prev_oor ? 8'h00 : mem_rdata;
        w_len_now  = (r_cnt == 4'd1) ? (r_prev_oor ? 4'd1 : decode_len(w_byte[7:4])) : r_len;
        w_last     = w_cap && (w_cap_idx == (w_len_now - 4'd1));
        // Only bytes below the length are ever captured, so any oor capture is an error.
        w_err_nx   = r_err | (w_cap && r_prev_oor);
        w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) && req;
        w_buf      = r_buf;
        if (w_cap) begin
            w_buf[w_bit_base +: 8] = w_byte;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (req) w_state_nx = S_FETCH;
            S_FETCH: if (w_last) w_state_nx = S_DONE;
            S_DONE:  w_state_nx = req ? S_FETCH : S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state and the issue logic.
    always_comb begin
        busy        = (r_state == S_FETCH);
        instr_valid = (r_state == S_DONE);
        mem_rd_en   = w_rd_en;
        mem_addr    = w_rd_en ? w_addr65[63:0] : 64'd0;
        instr       = r_instr;
        instr_len   = r_instr_len;
        mem_error   = r_mem_error;
        dbg_state   = r_state;
    end

    // Fetch bookkeeping, assembly and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_base      <= 64'd0;
            r_cnt       <= 4'd0;
            r_len       <= 4'd0;
            r_prev_oor  <= 1'b0;
            r_buf       <= '0;
            r_err       <= 1'b0;
            r_instr     <= '0;
            r_instr_len <= 4'd0;
            r_mem_error <= 1'b0;
        end else if (w_accept) begin
            r_base     <= pc_in;
            r_cnt      <= 4'd0;
            r_len      <= 4'd0;
            r_prev_oor <= 1'b0;
            r_buf      <= '0;
            r_err      <= 1'b0;
        end else if (r_state == S_FETCH) begin
            r_cnt      <= r_cnt + 4'd1;
            r_prev_oor <= w_oor;
            r_buf      <= w_buf;
            r_err      <= w_err_nx;
            if (r_cnt == 4'd1) begin
                r_len <= w_len_now;
            end
            if (w_last) begin
                r_instr     <= w_buf;
                r_instr_len <= w_len_now;
                r_mem_error <= w_err_nx;
            end
        end
    end

endmodule
